// File: rtl/alu_result_piso_pkg.sv
// Shared types and constants for the ALU result serializer.
// State encoding, payload/counter widths and the payload packing helper.
package alu_result_piso_pkg;

    localparam int PAYLOAD_W = 32;
    localparam int CNT_W     = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_DATA   = 2'd2,
        ST_PARITY = 2'd3
    } state_t;

    function automatic logic [PAYLOAD_W-1:0] pack_payload(
        input logic        cout,
        input logic [14:0] mul,
        input logic [15:0] res
    );
        return {cout, mul, res};
    endfunction

endpackage

// File: rtl/alu_result_piso_voter.sv
// Per-bit 2-of-3 majority voter cell.
// Used once per voted bit of the triplicated control registers.
module KP_Voter (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_y
);

    assign o_y = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/alu_result_piso.sv
// Serializes a voted ALU result as start/32 data/even-parity frame.
// FSM state and bit counter are triplicated and scrubbed every cycle.
module alu_result_piso #(
    parameter int PAYLOAD_W = alu_result_piso_pkg::PAYLOAD_W
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        RES_VALID,
    input  logic [15:0] RES_OUT,
    input  logic [14:0] RES_MUL,
    input  logic        RES_COUT,
    input  logic        CLR_OVR,
    output logic        DATA_OUT,
    output logic        BUSY,
    output logic        DONE,
    output logic        OVERRUN,
    output logic        TMR_ERR
);

    import alu_result_piso_pkg::*;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PAYLOAD_W - 1);

    state_t                 r_st0, r_st1, r_st2;
    logic [CNT_W-1:0]       r_cnt0, r_cnt1, r_cnt2;
    logic [PAYLOAD_W-1:0]   r_shift;
    logic                   r_par;
    logic                   r_done;
    logic                   r_ovr;

    logic [1:0]             w_st_v;
    state_t                 w_st;
    state_t                 w_st_nxt;
    logic [CNT_W-1:0]       w_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [PAYLOAD_W-1:0]   w_payload;
    logic                   w_accept;
    logic                   w_ovr_set;

    for (genvar g = 0; g < 2; g++) begin : g_st_vote
        KP_Voter u_vote (
            .i_a (r_st0[g]),
            .i_b (r_st1[g]),
            .i_c (r_st2[g]),
            .o_y (w_st_v[g])
        );
    end

    for (genvar g = 0; g < CNT_W; g++) begin : g_cnt_vote
        KP_Voter u_vote (
            .i_a (r_cnt0[g]),
            .i_b (r_cnt1[g]),
            .i_c (r_cnt2[g]),
            .o_y (w_cnt[g])
        );
    end

    assign w_st      = state_t'(w_st_v);
    assign w_payload = pack_payload(RES_COUT, RES_MUL, RES_OUT);
    assign w_accept  = (w_st == ST_IDLE) && RES_VALID;
    assign w_ovr_set = (w_st != ST_IDLE) && RES_VALID;

    always_comb begin
        w_st_nxt  = w_st;
        w_cnt_nxt = w_cnt;
        unique case (w_st)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (RES_VALID) w_st_nxt = ST_START;
            end
            ST_START: begin
                w_st_nxt  = ST_DATA;
                w_cnt_nxt = '0;
            end
            ST_DATA: begin
                if (w_cnt == LAST_BIT) begin
                    w_st_nxt  = ST_PARITY;
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = w_cnt + 1'b1;
                end
            end
            ST_PARITY: begin
                w_st_nxt  = ST_IDLE;
                w_cnt_nxt = '0;
            end
            default: begin
                w_st_nxt  = ST_IDLE;
                w_cnt_nxt = '0;
            end
        endcase
    end

    // Every copy reloads from the vote, so a single upset lasts one cycle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_st0  <= ST_IDLE;
            r_st1  <= ST_IDLE;
            r_st2  <= ST_IDLE;
            r_cnt0 <= '0;
            r_cnt1 <= '0;
            r_cnt2 <= '0;
        end else begin
            r_st0  <= w_st_nxt;
            r_st1  <= w_st_nxt;
            r_st2  <= w_st_nxt;
            r_cnt0 <= w_cnt_nxt;
            r_cnt1 <= w_cnt_nxt;
            r_cnt2 <= w_cnt_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_shift <= '0;
            r_par   <= 1'b0;
            r_done  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_done <= (w_st == ST_PARITY);
            r_ovr  <= w_ovr_set | (r_ovr & ~CLR_OVR);
            if (w_accept) begin
                r_shift <= w_payload;
                r_par   <= ^w_payload;
            end else if (w_st == ST_DATA) begin
                r_shift <= r_shift >> 1;
            end
        end
    end

    always_comb begin
        DATA_OUT = 1'b1;
        unique case (w_st)
            ST_IDLE:   DATA_OUT = 1'b1;
            ST_START:  DATA_OUT = 1'b0;
            ST_DATA:   DATA_OUT = r_shift[0];
            ST_PARITY: DATA_OUT = r_par;
            default:   DATA_OUT = 1'b1;
        endcase
    end

    assign BUSY    = (w_st != ST_IDLE);
    assign DONE    = r_done;
    assign OVERRUN = r_ovr;
    assign TMR_ERR = (r_st0 != w_st) | (r_st1 != w_st) | (r_st2 != w_st)
                   | (r_cnt0 != w_cnt) | (r_cnt1 != w_cnt)
                   | (r_cnt2 != w_cnt);

endmodule

// File: tb/tb_alu_result_piso.sv
// Directed bench for alu_result_piso with a serial-bit scoreboard.
// Expected frame bits are queued at each strobe and popped per cycle.
module tb_alu_result_piso;

    import alu_result_piso_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        RES_VALID;
    logic [15:0] RES_OUT;
    logic [14:0] RES_MUL;
    logic        RES_COUT;
    logic        CLR_OVR;
    logic        DATA_OUT;
    logic        BUSY;
    logic        DONE;
    logic        OVERRUN;
    logic        TMR_ERR;

    int   checks = 0;
    int   errors = 0;
    logic q[$];

    alu_result_piso dut (
        .CLK       (CLK),
        .RST       (RST),
        .RES_VALID (RES_VALID),
        .RES_OUT   (RES_OUT),
        .RES_MUL   (RES_MUL),
        .RES_COUT  (RES_COUT),
        .CLR_OVR   (CLR_OVR),
        .DATA_OUT  (DATA_OUT),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .OVERRUN   (OVERRUN),
        .TMR_ERR   (TMR_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [15:0] ro, input logic [14:0] rm,
                        input logic rc);
        logic [31:0] p;
        p = {rc, rm, ro};
        RES_OUT   = ro;
        RES_MUL   = rm;
        RES_COUT  = rc;
        RES_VALID = 1'b1;
        tick();
        RES_VALID = 1'b0;
        RES_OUT   = ~ro;
        RES_MUL   = ~rm;
        RES_COUT  = ~rc;
        q.delete();
        q.push_back(1'b0);
        for (int b = 0; b < 32; b++) q.push_back(p[b]);
        q.push_back(^p);
    endtask

    task automatic run_frame(input int inj, input bit clr, input int flt);
        logic e;
        for (int i = 0; i < 34; i++) begin
            if (i == flt) begin
                force dut.r_st1 = ST_PARITY;
                #1;
            end
            if (q.size() == 0) begin
                chk("queue_empty", 32'd1, 32'd0);
                e = 1'b1;
            end else begin
                e = q.pop_front();
            end
            chk("data_out", DATA_OUT, e);
            chk("busy", BUSY, 1'b1);
            chk("done_mid", DONE, 1'b0);
            chk("tmr_err", TMR_ERR, (i == flt));
            if (i == flt) release dut.r_st1;
            if (i == inj) begin
                RES_VALID = 1'b1;
                RES_OUT   = 16'h0F0F;
                RES_MUL   = 15'h5555;
                RES_COUT  = 1'b0;
                CLR_OVR   = clr;
            end
            tick();
            if (i == inj) begin
                RES_VALID = 1'b0;
                CLR_OVR   = 1'b0;
                chk("overrun_set", OVERRUN, 1'b1);
            end
            if (i == flt) begin
                chk("copy_scrub", dut.r_st1, ST_DATA);
                chk("tmr_clear", TMR_ERR, 1'b0);
            end
        end
        chk("done_pulse", DONE, 1'b1);
        chk("busy_done", BUSY, 1'b0);
        chk("idle_line", DATA_OUT, 1'b1);
    endtask

    initial begin
        RST       = 1'b0;
        RES_VALID = 1'b0;
        RES_OUT   = '0;
        RES_MUL   = '0;
        RES_COUT  = 1'b0;
        CLR_OVR   = 1'b0;
        #1;
        chk("rst_dout", DATA_OUT, 1'b1);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_done", DONE, 1'b0);
        chk("rst_ovr", OVERRUN, 1'b0);
        chk("rst_tmr", TMR_ERR, 1'b0);
        tick();
        RST = 1'b1;
        tick();
        chk("idle_dout", DATA_OUT, 1'b1);
        chk("idle_busy", BUSY, 1'b0);

        send(16'hA5A5, 15'h1234, 1'b1);
        run_frame(-1, 1'b0, -1);

        send(16'h0001, 15'h0000, 1'b0);
        run_frame(-1, 1'b0, -1);
        send(16'hFFFF, 15'h7FFF, 1'b1);
        run_frame(-1, 1'b0, -1);
        tick();
        chk("done_once", DONE, 1'b0);

        chk("ovr_before", OVERRUN, 1'b0);
        send(16'h1357, 15'h2468, 1'b0);
        run_frame(6, 1'b0, -1);
        CLR_OVR = 1'b1;
        tick();
        CLR_OVR = 1'b0;
        chk("ovr_cleared", OVERRUN, 1'b0);
        send(16'hBEEF, 15'h0ACE, 1'b1);
        run_frame(33, 1'b1, -1);

        send(16'h3C3C, 15'h0101, 1'b0);
        for (int i = 0; i < 11; i++) begin
            chk("abort_dout", DATA_OUT, q.pop_front());
            tick();
        end
        chk("abort_busy", BUSY, 1'b1);
        RST = 1'b0;
        #1;
        chk("mid_rst_dout", DATA_OUT, 1'b1);
        chk("mid_rst_busy", BUSY, 1'b0);
        chk("mid_rst_done", DONE, 1'b0);
        chk("mid_rst_ovr", OVERRUN, 1'b0);
        chk("mid_rst_tmr", TMR_ERR, 1'b0);
        q.delete();
        tick();
        tick();
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_done", DONE, 1'b0);
            chk("post_rst_busy", BUSY, 1'b0);
        end
        send(16'h8001, 15'h4002, 1'b0);
        run_frame(-1, 1'b0, -1);

        send(16'h6C6C, 15'h3333, 1'b1);
        run_frame(-1, 1'b0, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
